// File: rtl/core_pkg.sv
// Shared lane-array types: lane count, VRF payload widths and the per-lane load slice entry.
package core_pkg;

  localparam int unsigned NrLane = 4;
  localparam int unsigned DataW  = 32;
  localparam int unsigned StrbW  = DataW / 8;
  localparam int unsigned AddrW  = 8;
  localparam int unsigned IdW    = 3;

  typedef logic [DataW-1:0] vrf_data_t;
  typedef logic [StrbW-1:0] vrf_strb_t;
  typedef logic [AddrW-1:0] vrf_addr_t;
  typedef logic [IdW-1:0]   insn_id_t;

  typedef struct packed {
    vrf_data_t data;
    vrf_strb_t strb;
    vrf_addr_t addr;
    insn_id_t  id;
    logic      last;
  } lane_entry_t;

endpackage

// File: rtl/vldu_lane_dispatch_if.sv
// Load-beat handshake from the VLDU memory response path into the lane dispatcher.
interface vldu_lane_dispatch_if;

  logic                                        beat_valid_i;
  logic                                        beat_ready_o;
  core_pkg::vrf_data_t [core_pkg::NrLane-1:0]  beat_data_i;
  core_pkg::vrf_strb_t [core_pkg::NrLane-1:0]  beat_strb_i;
  core_pkg::vrf_addr_t                         beat_addr_i;
  core_pkg::insn_id_t                          beat_id_i;
  logic                                        beat_last_i;

  modport master (
    output beat_valid_i, beat_data_i, beat_strb_i, beat_addr_i, beat_id_i, beat_last_i,
    input  beat_ready_o
  );

  modport slave (
    input  beat_valid_i, beat_data_i, beat_strb_i, beat_addr_i, beat_id_i, beat_last_i,
    output beat_ready_o
  );

endinterface

// File: rtl/vldu_lane_dispatch.sv
// Splits VLDU load beats into per-lane slice FIFOs and pulses completion once every lane drained an
// instruction's last beat. Optional same-cycle FIFO bypass: VLDU_DISPATCH_BYPASS_EN.
module vldu_lane_dispatch
  import core_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DoneDepth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  vldu_lane_dispatch_if.slave      beat_if,
  output logic      [NrLane-1:0]   load_op_valid_o,
  input  logic      [NrLane-1:0]   load_op_gnt_i,
  output vrf_data_t [NrLane-1:0]   load_op_o,
  output vrf_strb_t [NrLane-1:0]   load_op_strb_o,
  output vrf_addr_t [NrLane-1:0]   load_op_addr_o,
  output insn_id_t  [NrLane-1:0]   load_id_o,
  output logic                     load_done_o,
  output insn_id_t                 load_done_id_o
);

  localparam int unsigned IdxW   = $clog2(Depth);
  localparam int unsigned PtrW   = IdxW + 1;
  localparam int unsigned DqIdxW = $clog2(DoneDepth);
  localparam int unsigned DqCntW = $clog2(DoneDepth + 1);
  localparam int unsigned CntW   = $clog2(Depth + DoneDepth) + 1;

  lane_entry_t       mem_q      [NrLane][Depth];
  logic [PtrW-1:0]   wr_ptr_q   [NrLane];
  logic [PtrW-1:0]   rd_ptr_q   [NrLane];
  logic [CntW-1:0]   last_cnt_q [NrLane];
  logic [CntW-1:0]   last_cnt_d [NrLane];
  insn_id_t          dq_mem_q   [DoneDepth];
  logic [DqIdxW-1:0] dq_wr_q, dq_rd_q;
  logic [DqCntW-1:0] dq_cnt_q, dq_cnt_d;
  logic              load_done_q;
  insn_id_t          load_done_id_q;

  lane_entry_t       beat_entry [NrLane];
  lane_entry_t       head       [NrLane];
  lane_entry_t       shown      [NrLane];
  logic [NrLane-1:0] full, empty, push, fifo_pop, lane_pop, pop_last, cnt_ok;
  logic              beat_ready, accept, dq_push, dq_full, dq_empty, done_fire;

  function automatic logic [DqIdxW-1:0] dq_next(input logic [DqIdxW-1:0] p);
    return (p == DqIdxW'(DoneDepth - 1)) ? '0 : p + DqIdxW'(1);
  endfunction

  // FIFO occupancy from pointers: equal index with differing MSB means full.
  always_comb begin : fifo_status
    for (int i = 0; i < NrLane; i++) begin
      full[i]       = (wr_ptr_q[i][IdxW] != rd_ptr_q[i][IdxW]) &&
                      (wr_ptr_q[i][IdxW-1:0] == rd_ptr_q[i][IdxW-1:0]);
      empty[i]      = (wr_ptr_q[i] == rd_ptr_q[i]);
      head[i]       = mem_q[i][rd_ptr_q[i][IdxW-1:0]];
      beat_entry[i] = '{data: beat_if.beat_data_i[i],
                        strb: beat_if.beat_strb_i[i],
                        addr: beat_if.beat_addr_i,
                        id:   beat_if.beat_id_i,
                        last: beat_if.beat_last_i};
    end
  end

  assign dq_full    = (dq_cnt_q == DqCntW'(DoneDepth));
  assign dq_empty   = (dq_cnt_q == '0);
  assign beat_ready = ~(|full) & ~(beat_if.beat_last_i & dq_full);
  assign accept     = beat_if.beat_valid_i & beat_ready;
  assign dq_push    = accept & beat_if.beat_last_i;
  assign beat_if.beat_ready_o = beat_ready;

  always_comb begin : lane_drain
    for (int i = 0; i < NrLane; i++) begin
`ifdef VLDU_DISPATCH_BYPASS_EN
      // An empty lane sees the incoming beat directly; a granted bypass never enters the FIFO.
      load_op_valid_o[i] = ~empty[i] | accept;
      shown[i]           = (empty[i] & accept) ? beat_entry[i] : head[i];
      lane_pop[i]        = load_op_valid_o[i] & load_op_gnt_i[i];
      fifo_pop[i]        = ~empty[i] & load_op_gnt_i[i];
      push[i]            = accept & ~(empty[i] & load_op_gnt_i[i]);
`else
      load_op_valid_o[i] = ~empty[i];
      shown[i]           = head[i];
      lane_pop[i]        = ~empty[i] & load_op_gnt_i[i];
      fifo_pop[i]        = lane_pop[i];
      push[i]            = accept;
`endif
      pop_last[i]       = lane_pop[i] & shown[i].last;
      cnt_ok[i]         = (last_cnt_q[i] != '0) | pop_last[i];
      load_op_o[i]      = shown[i].data;
      load_op_strb_o[i] = shown[i].strb;
      load_op_addr_o[i] = shown[i].addr;
      load_id_o[i]      = shown[i].id;
    end
  end

  // A lane popping its last slice this cycle already counts toward completion.
  assign done_fire = (&cnt_ok) & ~dq_empty;

  always_comb begin : counters
    dq_cnt_d = dq_cnt_q;
    if (dq_push && !done_fire) begin
      dq_cnt_d = dq_cnt_q + DqCntW'(1);
    end else if (!dq_push && done_fire) begin
      dq_cnt_d = dq_cnt_q - DqCntW'(1);
    end
    for (int i = 0; i < NrLane; i++) begin
      last_cnt_d[i] = last_cnt_q[i];
      if (pop_last[i] && !done_fire) begin
        last_cnt_d[i] = last_cnt_q[i] + CntW'(1);
      end else if (!pop_last[i] && done_fire) begin
        last_cnt_d[i] = last_cnt_q[i] - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : state_regs
    if (rst_i) begin
      for (int i = 0; i < NrLane; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        last_cnt_q[i] <= '0;
        for (int j = 0; j < Depth; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      for (int k = 0; k < DoneDepth; k++) begin
        dq_mem_q[k] <= '0;
      end
      dq_wr_q        <= '0;
      dq_rd_q        <= '0;
      dq_cnt_q       <= '0;
      load_done_q    <= 1'b0;
      load_done_id_q <= '0;
    end else begin
      for (int i = 0; i < NrLane; i++) begin
        if (push[i]) begin
          mem_q[i][wr_ptr_q[i][IdxW-1:0]] <= beat_entry[i];
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        end
        if (fifo_pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        end
        last_cnt_q[i] <= last_cnt_d[i];
      end
      if (dq_push) begin
        dq_mem_q[dq_wr_q] <= beat_if.beat_id_i;
        dq_wr_q           <= dq_next(dq_wr_q);
      end
      if (done_fire) begin
        dq_rd_q <= dq_next(dq_rd_q);
      end
      dq_cnt_q       <= dq_cnt_d;
      load_done_q    <= done_fire;
      load_done_id_q <= done_fire ? dq_mem_q[dq_rd_q] : '0;
    end
  end

  assign load_done_o    = load_done_q;
  assign load_done_id_o = load_done_id_q;

endmodule

// File: tb/tb_vldu_lane_dispatch.sv
// Directed bench for vldu_lane_dispatch: vector table plus multi-cycle corner sequences.
module tb_vldu_lane_dispatch;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic      [NrLane-1:0] gnt;
  logic      [NrLane-1:0] valid;
  vrf_data_t [NrLane-1:0] op;
  vrf_strb_t [NrLane-1:0] strb_o;
  vrf_addr_t [NrLane-1:0] addr_o;
  insn_id_t  [NrLane-1:0] id_o;
  logic                   done;
  insn_id_t               done_id;

  int total = 0;
  int bad   = 0;

  vldu_lane_dispatch_if bif ();

  vldu_lane_dispatch #(.Depth(4), .DoneDepth(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .beat_if         (bif),
    .load_op_valid_o (valid),
    .load_op_gnt_i   (gnt),
    .load_op_o       (op),
    .load_op_strb_o  (strb_o),
    .load_op_addr_o  (addr_o),
    .load_id_o       (id_o),
    .load_done_o     (done),
    .load_done_id_o  (done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bv;
    logic       last;
    insn_id_t   id;
    vrf_addr_t  addr;
    logic [3:0] g;
    logic       exp_ready;
    logic [3:0] exp_valid;
    vrf_addr_t  exp_addr;
    insn_id_t   exp_id;
    logic       exp_done;
    insn_id_t   exp_done_id;
  } vec_t;

  vec_t vecs[$];

  function automatic vrf_data_t mk_data(input vrf_addr_t a, input int lane);
    return vrf_data_t'({8'(lane), 8'h5A, 8'h00, a});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic bv, input logic last, input insn_id_t id,
                       input vrf_addr_t addr, input logic [3:0] g);
    bif.beat_valid_i = bv;
    bif.beat_last_i  = last;
    bif.beat_id_i    = id;
    bif.beat_addr_i  = addr;
    for (int i = 0; i < NrLane; i++) begin
      bif.beat_data_i[i] = mk_data(addr, i);
      bif.beat_strb_i[i] = vrf_strb_t'(1 << i);
    end
    gnt = g;
  endtask

  task automatic chk_lane(input int i, input vrf_addr_t a, input insn_id_t id);
    chk($sformatf("lane%0d_valid", i), 32'(valid[i]), 32'd1);
    chk($sformatf("lane%0d_addr", i), 32'(addr_o[i]), 32'(a));
    chk($sformatf("lane%0d_id", i), 32'(id_o[i]), 32'(id));
    chk($sformatf("lane%0d_data", i), 32'(op[i]), 32'(mk_data(a, i)));
    chk($sformatf("lane%0d_strb", i), 32'(strb_o[i]), 32'(vrf_strb_t'(1 << i)));
  endtask

  task automatic add(input logic bv, input logic last, input insn_id_t id, input vrf_addr_t addr,
                     input logic [3:0] g, input logic er, input logic [3:0] ev, input vrf_addr_t ea,
                     input insn_id_t eid, input logic ed, input insn_id_t edid);
    vec_t v;
    v = '{bv, last, id, addr, g, er, ev, ea, eid, ed, edid};
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 3'd0, 8'h00, 4'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_lane0_data", 32'(op[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bif.beat_ready_o), 32'd1);

    // Single beat then back-to-back beats, all lanes granting
`ifdef VLDU_DISPATCH_BYPASS_EN
    add(1, 1, 5, 8'h10, 4'hF, 1, 4'hF, 8'h10, 5, 0, 0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 1, 5);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);
    add(1, 0, 1, 8'h20, 4'hF, 1, 4'hF, 8'h20, 1, 0, 0);
    add(1, 0, 1, 8'h21, 4'hF, 1, 4'hF, 8'h21, 1, 0, 0);
    add(1, 0, 1, 8'h22, 4'hF, 1, 4'hF, 8'h22, 1, 0, 0);
    add(1, 1, 1, 8'h23, 4'hF, 1, 4'hF, 8'h23, 1, 0, 0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);
`else
    add(1, 1, 5, 8'h10, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'hF, 8'h10, 5, 0, 0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 1, 5);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);
    add(1, 0, 1, 8'h20, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);
    add(1, 0, 1, 8'h21, 4'hF, 1, 4'hF, 8'h20, 1, 0, 0);
    add(1, 0, 1, 8'h22, 4'hF, 1, 4'hF, 8'h21, 1, 0, 0);
    add(1, 1, 1, 8'h23, 4'hF, 1, 4'hF, 8'h22, 1, 0, 0);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'hF, 8'h23, 1, 0, 0);
`endif
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 1, 1);
    add(0, 0, 0, 8'h00, 4'hF, 1, 4'h0, 8'h00, 0, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      drive(vecs[n].bv, vecs[n].last, vecs[n].id, vecs[n].addr, vecs[n].g);
      #1;
      chk($sformatf("v%0d_ready", n), 32'(bif.beat_ready_o), 32'(vecs[n].exp_ready));
      chk($sformatf("v%0d_valid", n), 32'(valid), 32'(vecs[n].exp_valid));
      chk($sformatf("v%0d_done", n), 32'(done), 32'(vecs[n].exp_done));
      if (vecs[n].exp_done) chk($sformatf("v%0d_done_id", n), 32'(done_id), 32'(vecs[n].exp_done_id));
      for (int i = 0; i < NrLane; i++) begin
        if (vecs[n].exp_valid[i]) chk_lane(i, vecs[n].exp_addr, vecs[n].exp_id);
      end
    end

    // Mid-stream reset flushes three buffered beats and their pending completion
    @(negedge clk); drive(1, 0, 6, 8'h30, 4'h0); #1; chk("flush_rdy0", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(1, 0, 6, 8'h31, 4'h0); #1; chk("flush_rdy1", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(1, 1, 6, 8'h32, 4'h0); #1; chk("flush_rdy2", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(0, 0, 0, 8'h00, 4'h0); rst = 1'b1; #1;
    chk("flush_async_valid", 32'(valid), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("flush_valid", 32'(valid), 32'd0);
    chk("flush_ready", 32'(bif.beat_ready_o), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); drive(0, 0, 0, 8'h00, 4'hF); #1;
      chk($sformatf("flush_no_done%0d", c), 32'(done), 32'd0);
      chk($sformatf("flush_stay_empty%0d", c), 32'(valid), 32'd0);
    end

    // Backpressure: lane 2 stalled fills after four beats
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(1, 0, 2, vrf_addr_t'(8'h40 + k), 4'b1011); #1;
      chk($sformatf("bp_ready%0d", k), 32'(bif.beat_ready_o), (k < 4) ? 32'd1 : 32'd0);
    end
    chk_lane(2, 8'h40, 2);
    @(negedge clk); drive(1, 0, 2, 8'h44, 4'hF); #1;
    chk("bp_ready_release", 32'(bif.beat_ready_o), 32'd0);
    chk_lane(2, 8'h40, 2);
    @(negedge clk); drive(1, 0, 2, 8'h44, 4'hF); #1;
    chk("bp_ready_restored", 32'(bif.beat_ready_o), 32'd1);
    chk_lane(2, 8'h41, 2);
    @(negedge clk); drive(0, 0, 0, 8'h00, 4'hF); #1; chk_lane(2, 8'h42, 2);
    @(negedge clk); #1; chk_lane(2, 8'h43, 2);
    @(negedge clk); #1; chk_lane(2, 8'h44, 2);
    @(negedge clk); #1; chk("bp_drained", 32'(valid), 32'd0);
    chk("bp_no_done", 32'(done), 32'd0);

    // Skewed lanes: lane 3 stalled across two instructions
    @(negedge clk); drive(1, 0, 1, 8'h50, 4'b0111); #1; chk("sk_rdy0", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(1, 1, 1, 8'h51, 4'b0111); #1; chk("sk_rdy1", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(1, 1, 2, 8'h52, 4'b0111); #1; chk("sk_rdy2", 32'(bif.beat_ready_o), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(0, 1, 0, 8'h00, 4'b0111); #1;
      chk($sformatf("sk_wait_done%0d", c), 32'(done), 32'd0);
      chk_lane(3, 8'h50, 1);
      chk($sformatf("sk_dq_full_ready%0d", c), 32'(bif.beat_ready_o), 32'd0);
    end
    @(negedge clk); drive(0, 0, 0, 8'h00, 4'hF); #1;
    chk("sk_t0_done", 32'(done), 32'd0); chk_lane(3, 8'h50, 1);
    @(negedge clk); #1; chk("sk_t1_done", 32'(done), 32'd0); chk_lane(3, 8'h51, 1);
    @(negedge clk); #1; chk("sk_t2_done", 32'(done), 32'd1); chk("sk_t2_id", 32'(done_id), 32'd1);
    chk_lane(3, 8'h52, 2);
    @(negedge clk); #1; chk("sk_t3_done", 32'(done), 32'd1); chk("sk_t3_id", 32'(done_id), 32'd2);
    chk("sk_t3_valid", 32'(valid), 32'd0);
    @(negedge clk); #1; chk("sk_t4_done", 32'(done), 32'd0);

    // Done queue full blocks only last-beats
    @(negedge clk); drive(1, 1, 3, 8'h60, 4'h0); #1; chk("dq_rdy0", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(1, 1, 4, 8'h61, 4'h0); #1; chk("dq_rdy1", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(1, 1, 5, 8'h62, 4'h0); #1; chk("dq_full_last", 32'(bif.beat_ready_o), 32'd0);
    @(negedge clk); drive(1, 0, 5, 8'h63, 4'h0); #1; chk("dq_full_nonlast", 32'(bif.beat_ready_o), 32'd1);
    @(negedge clk); drive(0, 0, 0, 8'h00, 4'hF); #1;
    chk("dq_c0_done", 32'(done), 32'd0); chk_lane(0, 8'h60, 3);
    @(negedge clk); #1; chk("dq_c1_done", 32'(done), 32'd1); chk("dq_c1_id", 32'(done_id), 32'd3);
    chk_lane(0, 8'h61, 4);
    @(negedge clk); #1; chk("dq_c2_done", 32'(done), 32'd1); chk("dq_c2_id", 32'(done_id), 32'd4);
    chk_lane(0, 8'h63, 5);
    @(negedge clk); #1; chk("dq_c3_done", 32'(done), 32'd0); chk("dq_c3_valid", 32'(valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
